// File: rtl/ooo_pkg.sv
// rtl/ooo_pkg.sv - shared physical-register sizing and types for the OoO rename path
package ooo_pkg;

    localparam int NUM_PR = 64;
    localparam int NUM_AR = 32;
    localparam int PR_W   = $clog2(NUM_PR);

    typedef logic [PR_W-1:0] pr_t;

endpackage

// File: rtl/free_list_lane_offset.sv
// rtl/free_list_lane_offset.sv - prefix popcount: per-lane offset among requesting lanes plus total
module free_list_lane_offset #(
    parameter int N  = 2,
    parameter int OW = $clog2(N+1)
) (
    input  logic [N-1:0]    req,
    output logic [N*OW-1:0] offset,
    output logic [OW-1:0]   total
);

    always_comb begin : calc
        logic [OW-1:0] acc;
        acc    = '0;
        offset = '0;
        for (int i = 0; i < N; i++) begin
            offset[i*OW +: OW] = acc;
            acc = acc + OW'(req[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list_mw.sv
// rtl/free_list_mw.sv - multi-lane PR free list; FREE_LIST_CHECK_EN adds a double-free scoreboard driving err
module free_list_mw #(
    parameter int NUM_PR  = ooo_pkg::NUM_PR,
    parameter int NUM_AR  = ooo_pkg::NUM_AR,
    parameter int ALLOC_W = 2,
    parameter int FREE_W  = 2,
    localparam int PR_W   = $clog2(NUM_PR)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ALLOC_W-1:0]       alloc_req,
    input  logic                     hazard_stall,
    output logic [ALLOC_W*PR_W-1:0]  alloc_pr,
    output logic [ALLOC_W-1:0]       alloc_valid,
    output logic                     alloc_stall,
    input  logic [FREE_W-1:0]        retire_vld,
    input  logic [FREE_W*PR_W-1:0]   retire_pr,
    input  logic                     recover,
    input  logic [FREE_W-1:0]        flush_vld,
    input  logic [FREE_W*PR_W-1:0]   flush_pr,
    output logic [PR_W:0]            count,
    output logic                     empty,
    output logic                     err
);

    localparam int DEPTH  = NUM_PR - NUM_AR;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CW     = PR_W + 1;
    localparam int PUSH_N = 2 * FREE_W;
    localparam int AOW    = $clog2(ALLOC_W + 1);
    localparam int POW    = $clog2(PUSH_N + 1);

    // Depth need not be a power of two, so wrap with an explicit compare.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                  input logic [PTR_W-1:0] off);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {1'b0, off};
        if (s >= (PTR_W+1)'(DEPTH))
            s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    logic [PR_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [ALLOC_W*AOW-1:0] alloc_off;
    logic [AOW-1:0]        alloc_n;
    logic [PUSH_N-1:0]     push_req;
    logic [PUSH_N*PR_W-1:0] push_pr;
    logic [PUSH_N*POW-1:0] push_off;
    logic [POW-1:0]        push_n;
    logic                  commit;
    logic [CW-1:0]         pop_n;

    // Retire lanes occupy the low push slots so they land ahead of flush lanes.
    assign push_req = {flush_vld & {FREE_W{recover}}, retire_vld};
    assign push_pr  = {flush_pr, retire_pr};

    free_list_lane_offset #(.N(ALLOC_W), .OW(AOW)) u_alloc_off (
        .req    (alloc_req),
        .offset (alloc_off),
        .total  (alloc_n)
    );

    free_list_lane_offset #(.N(PUSH_N), .OW(POW)) u_push_off (
        .req    (push_req),
        .offset (push_off),
        .total  (push_n)
    );

    always_comb begin
        alloc_stall = CW'(alloc_n) > count;
        commit      = (alloc_n != '0) && !alloc_stall && !hazard_stall && !recover;
        alloc_pr    = '0;
        alloc_valid = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_req[i]) begin
                alloc_pr[i*PR_W +: PR_W] = mem[wrap_add(head, PTR_W'(alloc_off[i*AOW +: AOW]))];
                alloc_valid[i]           = commit;
            end
        end
        pop_n = commit ? CW'(alloc_n) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= PR_W'(NUM_AR + i);
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
        end else begin
            for (int j = 0; j < PUSH_N; j++) begin
                if (push_req[j])
                    mem[wrap_add(tail, PTR_W'(push_off[j*POW +: POW]))] <= push_pr[j*PR_W +: PR_W];
            end
            if (commit)
                head <= wrap_add(head, PTR_W'(alloc_n));
            tail  <= wrap_add(tail, PTR_W'(push_n));
            count <= count - pop_n + CW'(push_n);
        end
    end

    assign empty = (count == '0);

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PR-1:0] sb;
    logic [NUM_PR-1:0] sb_next;
    logic              dbl;

    // Pops clear first, so a duplicate within one cycle hits the bit set by the earlier lane.
    always_comb begin
        sb_next = sb;
        dbl     = 1'b0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_valid[i])
                sb_next[alloc_pr[i*PR_W +: PR_W]] = 1'b0;
        end
        for (int j = 0; j < PUSH_N; j++) begin
            if (push_req[j]) begin
                if (sb_next[push_pr[j*PR_W +: PR_W]])
                    dbl = 1'b1;
                sb_next[push_pr[j*PR_W +: PR_W]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PR; i++)
                sb[i] <= (i >= NUM_AR);
            err <= 1'b0;
        end else begin
            sb <= sb_next;
            if (dbl)
                err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list_mw.sv
// tb/tb_free_list_mw.sv - scoreboard bench for free_list_mw (honours FREE_LIST_CHECK_EN for err)
module tb_free_list_mw;
    import ooo_pkg::*;

    localparam int AW    = 2;
    localparam int FW    = 2;
    localparam int DEPTH = NUM_PR - NUM_AR;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [AW-1:0]     alloc_req = '0;
    logic              hazard_stall = 1'b0;
    logic [AW*PR_W-1:0] alloc_pr;
    logic [AW-1:0]     alloc_valid;
    logic              alloc_stall;
    logic [FW-1:0]     retire_vld = '0;
    logic [FW*PR_W-1:0] retire_pr = '0;
    logic              recover = 1'b0;
    logic [FW-1:0]     flush_vld = '0;
    logic [FW*PR_W-1:0] flush_pr = '0;
    logic [PR_W:0]     count;
    logic              empty;
    logic              err;

    always #5 clk = ~clk;

    free_list_mw #(.NUM_PR(NUM_PR), .NUM_AR(NUM_AR), .ALLOC_W(AW), .FREE_W(FW)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .hazard_stall (hazard_stall),
        .alloc_pr     (alloc_pr),
        .alloc_valid  (alloc_valid),
        .alloc_stall  (alloc_stall),
        .retire_vld   (retire_vld),
        .retire_pr    (retire_pr),
        .recover      (recover),
        .flush_vld    (flush_vld),
        .flush_pr     (flush_pr),
        .count        (count),
        .empty        (empty),
        .err          (err)
    );

    typedef struct {
        logic [PR_W-1:0] pr0;
        logic [PR_W-1:0] pr1;
        logic            chk0;
        logic            chk1;
        logic [1:0]      vld;
        logic            stall;
        int              cnt;
        logic            err;
    } exp_t;

    exp_t            exp_q[$];
    pr_t             fl_q[$];
    pr_t             outst[$];
    logic [NUM_PR-1:0] mdl_in;
    logic            mdl_err;
    int              n_chk = 0;
    int              n_fail = 0;
    pr_t             obs_pr0;
    pr_t             obs_pr1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        fl_q.delete();
        outst.delete();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++)
            fl_q.push_back(pr_t'(NUM_AR + i));
        mdl_in = '0;
        for (int i = NUM_AR; i < NUM_PR; i++)
            mdl_in[i] = 1'b1;
        mdl_err = 1'b0;
    endtask

    function automatic pr_t fl_at(input int idx);
        return (idx < fl_q.size()) ? fl_q[idx] : pr_t'(0);
    endfunction

    function automatic logic exp_err_now();
`ifdef FREE_LIST_CHECK_EN
        return mdl_err;
`else
        return 1'b0;
`endif
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        alloc_req = '0; hazard_stall = 1'b0; retire_vld = '0; recover = 1'b0; flush_vld = '0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_count", 32'(count), DEPTH);
        chk("rst_empty", 32'(empty), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall", 32'(alloc_stall), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cycle(input logic [1:0] req, input logic hz,
                         input logic [1:0] rv, input pr_t r0, input pr_t r1,
                         input logic rec, input logic [1:0] fv, input pr_t f0, input pr_t f1);
        exp_t e;
        exp_t got;
        int   n;
        logic commit;
        pr_t  p;
        pr_t  pushes[$];
        @(negedge clk);
        alloc_req = req; hazard_stall = hz; recover = rec;
        retire_vld = rv; retire_pr = {r1, r0};
        flush_vld = fv; flush_pr = {f1, f0};
        n       = int'(req[0]) + int'(req[1]);
        e.stall = n > fl_q.size();
        commit  = (n > 0) && !e.stall && !hz && !rec;
        e.vld   = commit ? req : 2'b00;
        e.pr0   = req[0] ? fl_at(0) : pr_t'(0);
        e.pr1   = req[1] ? fl_at(req[0] ? 1 : 0) : pr_t'(0);
        e.chk0  = !req[0] || !e.stall;
        e.chk1  = !req[1] || !e.stall;
        e.cnt   = fl_q.size();
        e.err   = exp_err_now();
        exp_q.push_back(e);
        #2;
        got = exp_q.pop_front();
        obs_pr0 = alloc_pr[PR_W-1:0];
        obs_pr1 = alloc_pr[2*PR_W-1:PR_W];
        chk("alloc_valid", 32'(alloc_valid), 32'(got.vld));
        chk("alloc_stall", 32'(alloc_stall), 32'(got.stall));
        if (got.chk0) chk("alloc_pr0", 32'(obs_pr0), 32'(got.pr0));
        if (got.chk1) chk("alloc_pr1", 32'(obs_pr1), 32'(got.pr1));
        chk("count", 32'(count), got.cnt);
        chk("empty", 32'(empty), 32'(got.cnt == 0));
        chk("err", 32'(err), 32'(got.err));
        if (commit) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i]) begin
                    p = fl_q.pop_front();
                    mdl_in[p] = 1'b0;
                    outst.push_back(p);
                end
            end
        end
        if (rv[0]) pushes.push_back(r0);
        if (rv[1]) pushes.push_back(r1);
        if (rec && fv[0]) pushes.push_back(f0);
        if (rec && fv[1]) pushes.push_back(f1);
        foreach (pushes[k]) begin
            if (mdl_in[pushes[k]]) mdl_err = 1'b1;
            mdl_in[pushes[k]] = 1'b1;
            fl_q.push_back(pushes[k]);
        end
    endtask

    task automatic idle(input logic [1:0] req);
        cycle(req, 1'b0, 2'b00, 0, 0, 1'b0, 2'b00, 0, 0);
    endtask

    initial begin
        logic [1:0] rv;
        logic [1:0] fv;
        pr_t        rp[2];
        pr_t        fp[2];
        logic       rec;

        model_reset();
        repeat (2) @(negedge clk);
        chk("init_count", 32'(count), DEPTH);
        chk("init_err", 32'(err), 0);
        rst = 1'b0;

        idle(2'b11);
        chk("first_pr0", 32'(obs_pr0), 32);
        chk("first_pr1", 32'(obs_pr1), 33);
        cycle(2'b01, 1'b1, 2'b00, 0, 0, 1'b0, 2'b00, 0, 0);
        chk("second_pr0", 32'(obs_pr0), 34);

        apply_reset();
        idle(2'b10);
        chk("lone_pr1", 32'(obs_pr1), 32);
        chk("lone_pr0", 32'(obs_pr0), 0);
        idle(2'b00);

        apply_reset();
        repeat (16) idle(2'b11);
        idle(2'b00);
        cycle(2'b01, 1'b0, 2'b01, 5, 0, 1'b0, 2'b00, 0, 0);
        cycle(2'b01, 1'b0, 2'b01, 6, 0, 1'b0, 2'b00, 0, 0);
        chk("no_bypass_pr0", 32'(obs_pr0), 5);
        idle(2'b11);
        cycle(2'b01, 1'b1, 2'b01, 7, 0, 1'b0, 2'b00, 0, 0);
        cycle(2'b11, 1'b0, 2'b11, 8, 9, 1'b1, 2'b11, 40, 41);
        cycle(2'b00, 1'b0, 2'b00, 0, 0, 1'b0, 2'b11, 50, 51);
        idle(2'b11);
        idle(2'b11);
        chk("order_pr0", 32'(obs_pr0), 8);
        chk("order_pr1", 32'(obs_pr1), 9);
        idle(2'b11);
        chk("order_pr2", 32'(obs_pr0), 40);
        chk("order_pr3", 32'(obs_pr1), 41);
        idle(2'b00);

        cycle(2'b00, 1'b0, 2'b01, 3, 0, 1'b0, 2'b00, 0, 0);
        cycle(2'b00, 1'b0, 2'b01, 3, 0, 1'b0, 2'b00, 0, 0);
        idle(2'b00);
`ifdef FREE_LIST_CHECK_EN
        chk("dbl_err", 32'(err), 1);
`else
        chk("dbl_err", 32'(err), 0);
`endif
        idle(2'b00);
        apply_reset();

        for (int c = 0; c < 300; c++) begin
            rec = ($urandom_range(0, 5) == 0);
            for (int l = 0; l < 2; l++) begin
                rv[l] = 1'b0; fv[l] = 1'b0; rp[l] = 0; fp[l] = 0;
                if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
                    rv[l] = 1'b1; rp[l] = outst.pop_front();
                end
                if (rec && outst.size() > 0 && $urandom_range(0, 1) == 0) begin
                    fv[l] = 1'b1; fp[l] = outst.pop_front();
                end else if (!rec && $urandom_range(0, 3) == 0) begin
                    fv[l] = 1'b1;
                end
            end
            cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), rv, rp[0], rp[1],
                  rec, fv, fp[0], fp[1]);
        end
        idle(2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
